// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Two-requester round-robin arbiter and sequencer in front of one shared
// combinational ALU. A request is accepted over a valid/ready handshake, its
// operands are registered onto the ALU inputs, the ALU result is captured
// after one settle cycle, and the result is returned to the requester that
// issued it over a per-requester valid/ready response channel.
//
// Transaction flow:  IDLE --accept--> EXEC --(1 cycle)--> RESP --rsp_ready--> IDLE
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst        synchronous, active-high reset
//   i_req_valid  per-requester request valid (bit k = requester k)
//   o_req_ready  per-requester request accept (only the granted bit, only in IDLE)
//   i_req_op1    operand 1, requester k in bits [k*DW +: DW]
//   i_req_op2    operand 2, same packing
//   i_req_ctrl   ALU control code, same packing
//   o_rsp_valid  per-requester response valid (only the owner's bit, only in RESP)
//   i_rsp_ready  per-requester response accept (non-owner bit ignored)
//   o_rsp_dat    shared result bus, meaningful for the requester whose valid is set
//   o_rsp_err    illegal control code flag, qualified by o_rsp_valid
//   o_alu_op1    registered operand 1 to the ALU
//   o_alu_op2    registered operand 2 to the ALU
//   o_alu_ctrl   registered control code to the ALU
//   i_alu_dat    combinational result from the ALU
//   o_busy       high whenever a transaction is in flight
//   o_op_cnt     number of completed responses, wraps to zero
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int DW      = 4,
    parameter int CW      = 3,
    parameter int RW      = 8,
    parameter int NUM_OPS = 5,
    parameter int CNTW    = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic [1:0]        i_req_valid,
    output logic [1:0]        o_req_ready,
    input  logic [2*DW-1:0]   i_req_op1,
    input  logic [2*DW-1:0]   i_req_op2,
    input  logic [2*CW-1:0]   i_req_ctrl,

    output logic [1:0]        o_rsp_valid,
    input  logic [1:0]        i_rsp_ready,
    output logic [RW-1:0]     o_rsp_dat,
    output logic              o_rsp_err,

    output logic [DW-1:0]     o_alu_op1,
    output logic [DW-1:0]     o_alu_op2,
    output logic [CW-1:0]     o_alu_ctrl,
    input  logic [RW-1:0]     i_alu_dat,

    output logic              o_busy,
    output logic [CNTW-1:0]   o_op_cnt
);

    // One extra bit so NUM_OPS == 2**CW (every code legal) is representable.
    localparam logic [CW:0] LP_NUM_OPS = NUM_OPS[CW:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t             r_state;
    logic               r_rr;        // requester favoured when both are valid
    logic               r_owner;     // requester of the transaction in flight
    logic               r_err;       // captured illegal-ctrl flag for the transaction
    logic [DW-1:0]      r_alu_op1;
    logic [DW-1:0]      r_alu_op2;
    logic [CW-1:0]      r_alu_ctrl;
    logic [RW-1:0]      r_rsp_dat;
    logic               r_rsp_err;
    logic [CNTW-1:0]    r_op_cnt;

    // -------------------------------------------------------------------------
    // Wires
    // -------------------------------------------------------------------------
    state_t             w_next_state;
    logic               w_grant;
    logic               w_accept;
    logic               w_rsp_fire;
    logic [DW-1:0]      w_sel_op1;
    logic [DW-1:0]      w_sel_op2;
    logic [CW-1:0]      w_sel_ctrl;
    logic               w_sel_illegal;

    // -------------------------------------------------------------------------
    // Grant: a lone requester always wins; on contention the rr pointer decides.
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_grant = 1'b0;
        case (i_req_valid)
            2'b01:   w_grant = 1'b0;
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = r_rr;
            default: w_grant = 1'b0;
        endcase
    end

    assign w_accept   = (r_state == S_IDLE) && (|i_req_valid);
    assign w_rsp_fire = (r_state == S_RESP) && i_rsp_ready[r_owner];

    // Operand mux for the granted requester.
    assign w_sel_op1  = w_grant ? i_req_op1[DW +: DW]  : i_req_op1[0 +: DW];
    assign w_sel_op2  = w_grant ? i_req_op2[DW +: DW]  : i_req_op2[0 +: DW];
    assign w_sel_ctrl = w_grant ? i_req_ctrl[CW +: CW] : i_req_ctrl[0 +: CW];

    assign w_sel_illegal = ({1'b0, w_sel_ctrl} >= LP_NUM_OPS);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples its inputs from before the edge, independent of block order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept)   w_next_state = S_EXEC;
            S_EXEC:                 w_next_state = S_RESP;
            S_RESP: if (w_rsp_fire) w_next_state = S_IDLE;
            default:                w_next_state = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        o_req_ready = 2'b00;
        o_rsp_valid = 2'b00;
        o_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                o_busy               = 1'b0;
                o_req_ready[w_grant] = i_req_valid[w_grant];
            end
            S_RESP: begin
                o_rsp_valid[r_owner] = 1'b1;
            end
            default: begin
                o_busy = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath and bookkeeping registers
    // -------------------------------------------------------------------------
    // NOTE: every register here has a reset value, including the data-carrying
    // ones, because the result and ALU operand outputs must read zero after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr       <= 1'b0;
            r_owner    <= 1'b0;
            r_err      <= 1'b0;
            r_alu_op1  <= '0;
            r_alu_op2  <= '0;
            r_alu_ctrl <= '0;
            r_rsp_dat  <= '0;
            r_rsp_err  <= 1'b0;
            r_op_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_alu_op1  <= w_sel_op1;
                r_alu_op2  <= w_sel_op2;
                r_alu_ctrl <= w_sel_ctrl;
                r_owner    <= w_grant;
                r_err      <= w_sel_illegal;
            end

            // The ALU has had a full cycle to settle on the registered operands.
            if (r_state == S_EXEC) begin
                r_rsp_dat <= r_err ? '0 : i_alu_dat;
                r_rsp_err <= r_err;
            end

            // Hand priority to the other requester once this one is served.
            if (w_rsp_fire) begin
                r_rr     <= ~r_owner;
                r_op_cnt <= r_op_cnt + CNTW'(1);
            end
        end
    end

    assign o_alu_op1  = r_alu_op1;
    assign o_alu_op2  = r_alu_op2;
    assign o_alu_ctrl = r_alu_ctrl;
    assign o_rsp_dat  = r_rsp_dat;
    assign o_rsp_err  = r_rsp_err;
    assign o_op_cnt   = r_op_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter. Two instances share the stimulus: the
// default one (CNTW=16) and a CNTW=4 one used to observe counter wrap. Each
// has an ALU stub returning {op1, op2}. A transaction-level model tracks what
// the outputs must be; a negedge compare process checks it every cycle, and
// directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [7:0]  req_op1;
    logic [7:0]  req_op2;
    logic [5:0]  req_ctrl;
    logic [1:0]  rsp_ready;

    logic [1:0]  req_ready,  req_ready4;
    logic [1:0]  rsp_valid,  rsp_valid4;
    logic [7:0]  rsp_dat,    rsp_dat4;
    logic        rsp_err,    rsp_err4;
    logic [3:0]  alu_op1,    alu_op1_4;
    logic [3:0]  alu_op2,    alu_op2_4;
    logic [2:0]  alu_ctrl,   alu_ctrl4;
    logic        busy,       busy4;
    logic [15:0] op_cnt;
    logic [3:0]  op_cnt4;

    alu_arbiter u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_op1(req_op1), .i_req_op2(req_op2), .i_req_ctrl(req_ctrl),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_dat(rsp_dat), .o_rsp_err(rsp_err),
        .o_alu_op1(alu_op1), .o_alu_op2(alu_op2), .o_alu_ctrl(alu_ctrl),
        .i_alu_dat({alu_op1, alu_op2}),
        .o_busy(busy), .o_op_cnt(op_cnt)
    );

    alu_arbiter #(.CNTW(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready4),
        .i_req_op1(req_op1), .i_req_op2(req_op2), .i_req_ctrl(req_ctrl),
        .o_rsp_valid(rsp_valid4), .i_rsp_ready(rsp_ready),
        .o_rsp_dat(rsp_dat4), .o_rsp_err(rsp_err4),
        .o_alu_op1(alu_op1_4), .o_alu_op2(alu_op2_4), .o_alu_ctrl(alu_ctrl4),
        .i_alu_dat({alu_op1_4, alu_op2_4}),
        .o_busy(busy4), .o_op_cnt(op_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Transaction-level model. A transaction is either absent or in flight;
    // while in flight it has an age (0 = ALU settling, 1 = response offered).
    // -------------------------------------------------------------------------
    bit          m_live  = 0;
    bit          m_busy  = 0;
    int          m_age   = 0;
    bit          m_rr    = 0;
    bit          m_owner = 0;
    bit          m_bad   = 0;
    int          m_cnt   = 0;
    logic [3:0]  m_op1   = '0;
    logic [3:0]  m_op2   = '0;
    logic [2:0]  m_ctrl  = '0;
    logic [7:0]  m_dat   = '0;
    bit          m_err   = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1; m_busy = 0; m_age = 0; m_rr = 0; m_owner = 0; m_bad = 0;
            m_cnt = 0; m_op1 = '0; m_op2 = '0; m_ctrl = '0; m_dat = '0; m_err = 0;
        end else if (!m_busy) begin
            if (req_valid != 2'b00) begin
                if (req_valid == 2'b11) m_owner = m_rr;
                else                    m_owner = req_valid[1];
                m_op1  = m_owner ? req_op1[7:4]  : req_op1[3:0];
                m_op2  = m_owner ? req_op2[7:4]  : req_op2[3:0];
                m_ctrl = m_owner ? req_ctrl[5:3] : req_ctrl[2:0];
                m_bad  = (m_ctrl >= 3'd5);
                m_busy = 1;
                m_age  = 0;
            end
        end else if (m_age == 0) begin
            m_age = 1;
            m_dat = m_bad ? 8'h00 : {m_op1, m_op2};
            m_err = m_bad;
        end else if (rsp_ready[m_owner]) begin
            m_busy = 0;
            m_cnt  = m_cnt + 1;
            m_rr   = !m_owner;
        end
    end

    // Responses seen on completing cycles, for the fairness check.
    logic [1:0] q_owner[$];
    logic [7:0] q_dat[$];

    always @(negedge clk) begin
        if (m_live) begin
            logic [1:0] exp_ready;
            logic [1:0] exp_valid;
            if (m_busy)                  exp_ready = 2'b00;
            else if (req_valid == 2'b11) exp_ready = m_rr ? 2'b10 : 2'b01;
            else                         exp_ready = req_valid;
            exp_valid = (m_busy && m_age == 1) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;

            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            check("busy",      32'(busy),      32'(m_busy));
            check("alu_op1",   32'(alu_op1),   32'(m_op1));
            check("alu_op2",   32'(alu_op2),   32'(m_op2));
            check("alu_ctrl",  32'(alu_ctrl),  32'(m_ctrl));
            check("rsp_dat",   32'(rsp_dat),   32'(m_dat));
            check("rsp_err",   32'(rsp_err),   32'(m_err));
            check("op_cnt",    32'(op_cnt),    32'(m_cnt[15:0]));
            check("op_cnt4",   32'(op_cnt4),   32'(m_cnt[3:0]));
            check("rsp_valid4", 32'(rsp_valid4), 32'(exp_valid));

            if ((rsp_valid & rsp_ready) != 2'b00) begin
                q_owner.push_back(rsp_valid);
                q_dat.push_back(rsp_dat);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (inputs change only 1 time unit after a rising edge)
    // -------------------------------------------------------------------------
    task automatic do_reset();
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Present a request from requester k and return just after it is accepted.
    task automatic issue(input int k, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] c);
        int t;
        req_valid = 2'b00;
        req_valid[k] = 1'b1;
        req_op1[k*4 +: 4]  = a;
        req_op2[k*4 +: 4]  = b;
        req_ctrl[k*3 +: 3] = c;
        t = 0;
        do begin
            @(posedge clk); #1; t++;
        end while (!m_busy && t < 20);
        check("accept_timeout", 32'(m_busy), 32'd1);
        req_valid = 2'b00;
    endtask

    task automatic finish_op();
        int t;
        t = 0;
        while (m_busy && t < 50) begin
            @(posedge clk); #1; t++;
        end
        check("finish_timeout", 32'(m_busy), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_dat"},   32'(rsp_dat),   32'd0);
        check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        check({tag, "_alu_op1"},   32'(alu_op1),   32'd0);
        check({tag, "_alu_op2"},   32'(alu_op2),   32'd0);
        check({tag, "_alu_ctrl"},  32'(alu_ctrl),  32'd0);
        check({tag, "_op_cnt"},    32'(op_cnt),    32'd0);
    endtask

    initial begin
        int t;
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11;
        req_op1 = '0; req_op2 = '0; req_ctrl = '0;

        // ---- Reset state ----------------------------------------------------
        do_reset();
        @(negedge clk);
        check_reset_values("reset");
        check("reset_req_ready", 32'(req_ready), 32'd0);

        // ---- Single request, fixed latency ----------------------------------
        @(posedge clk); #1;
        req_valid = 2'b01; req_op1 = 8'h0A; req_op2 = 8'h03; req_ctrl = 6'd1;
        @(negedge clk);
        check("t1_req_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        check("t1_exec_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        check("t1_resp_valid", 32'(rsp_valid), 32'h1);
        check("t1_dat",        32'(rsp_dat),   32'hA3);
        check("t1_err",        32'(rsp_err),   32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_cnt",        32'(op_cnt),    32'd1);
        check("t1_idle_valid", 32'(rsp_valid), 32'h0);

        // ---- Both requesting continuously: alternation ----------------------
        do_reset();
        req_valid = 2'b11; req_op1 = 8'h31; req_op2 = 8'h42; req_ctrl = 6'd0;
        q_owner.delete(); q_dat.delete();
        t = 0;
        do begin
            @(posedge clk); #1; t++;
        end while (m_cnt != 8 && t < 200);
        req_valid = 2'b00;
        check("t2_timeout", 32'(m_cnt), 32'd8);
        check("t2_resp_count", 32'(q_owner.size()), 32'd8);
        for (int i = 0; i < 8 && i < q_owner.size(); i++) begin
            check($sformatf("t2_owner%0d", i), 32'(q_owner[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
            check($sformatf("t2_dat%0d", i),   32'(q_dat[i]),   (i % 2 == 0) ? 32'h12 : 32'h34);
        end
        @(negedge clk);
        check("t2_cnt", 32'(op_cnt), 32'd8);

        // ---- Illegal control code -------------------------------------------
        @(posedge clk); #1;
        issue(1, 4'hF, 4'hF, 3'd6);
        @(negedge clk);
        @(negedge clk);
        check("t3_valid", 32'(rsp_valid), 32'h2);
        check("t3_dat",   32'(rsp_dat),   32'h00);
        check("t3_err",   32'(rsp_err),   32'h1);
        finish_op();
        check("t3_cnt",   32'(m_cnt),     32'd9);

        // ---- Response backpressure ------------------------------------------
        rsp_ready = 2'b00;
        issue(0, 4'h5, 4'h6, 3'd2);
        req_valid = 2'b11; req_op1 = 8'h75; req_op2 = 8'h86; req_ctrl = 6'o02;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_valid",    32'(rsp_valid), 32'h1);
            check("t4_dat",      32'(rsp_dat),   32'h56);
            check("t4_alu_op1",  32'(alu_op1),   32'h5);
            check("t4_alu_op2",  32'(alu_op2),   32'h6);
            check("t4_alu_ctrl", 32'(alu_ctrl),  32'h2);
            check("t4_ready",    32'(req_ready), 32'h0);
        end
        @(posedge clk); #1 rsp_ready = 2'b11;
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        check("t4_cnt",  32'(op_cnt), 32'd10);
        check("t4_busy", 32'(busy),   32'd0);

        // ---- Counter wrap on the CNTW=4 instance ----------------------------
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            issue(i % 2, 4'(i), 4'(i + 1), 3'(i % 5));
            finish_op();
        end
        @(negedge clk);
        check("t5_cnt4_15", 32'(op_cnt4), 32'd15);
        @(posedge clk); #1;
        issue(0, 4'h2, 4'h9, 3'd4);
        finish_op();
        @(negedge clk);
        check("t5_cnt4_0", 32'(op_cnt4), 32'd0);
        check("t5_cnt16",  32'(op_cnt),  32'd16);

        // ---- Reset during EXEC ----------------------------------------------
        @(posedge clk); #1;
        issue(0, 4'h1, 4'h1, 3'd0);
        finish_op();                 // leaves rr pointing at requester 1
        issue(0, 4'hC, 4'hD, 3'd3);  // now in EXEC
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values("rst_exec");
        @(posedge clk); #1 req_valid = 2'b11;
        @(negedge clk);
        check("rst_exec_rr", 32'(req_ready), 32'h1);
        @(posedge clk); #1 req_valid = 2'b00;
        finish_op();

        // ---- Reset during RESP ----------------------------------------------
        rsp_ready = 2'b00;
        issue(0, 4'hE, 4'h7, 3'd2);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_resp_valid", 32'(rsp_valid), 32'h1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; rsp_ready = 2'b11;
        @(negedge clk);
        check_reset_values("rst_resp");
        @(posedge clk); #1 req_valid = 2'b11;
        @(negedge clk);
        check("rst_resp_rr", 32'(req_ready), 32'h1);
        @(posedge clk); #1 req_valid = 2'b00;
        finish_op();
        @(negedge clk);
        check("final_cnt", 32'(op_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
